// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with exception drain (optional PIPE_CTRL_PERF_EN counters)
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [31:0] EXC_ERET   = 32'h0000000e;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        bus_busy;

    assign bus_busy = stallreq_if | stallreq_mem;

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = 32'h0;

        case (state_q)
            RUN: begin
                if (excepttype != 32'h0) begin
                    if (bus_busy) begin
                        // An outstanding bus transaction must complete before redirecting.
                        exc_d   = excepttype;
                        epc_d   = cp0_epc;
                        stall   = STALL_ALL;
                        state_d = DRAIN;
                    end else begin
                        flush  = 1'b1;
                        new_pc = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
                    end
                end else if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall = STALL_EX;
                end else if (stallreq_id) begin
                    stall = STALL_ID;
                end else if (stallreq_if) begin
                    stall = STALL_ID;
                end
            end
            DRAIN: begin
                if (bus_busy) begin
                    stall = STALL_ALL;
                end else begin
                    flush   = 1'b1;
                    new_pc  = (exc_q == EXC_ERET) ? epc_q : EXC_VECTOR;
                    exc_d   = 32'h0;
                    epc_d   = 32'h0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            stall  = STALL_NONE;
            flush  = 1'b0;
            new_pc = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            exc_q   <= 32'h0;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall != STALL_NONE) && (stall_cnt_q != 32'hFFFFFFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFFFFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype   (excepttype),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and apply a new input vector.
    task automatic drive(input logic r, input logic rif, input logic rid, input logic rex,
                         input logic rmem, input logic [31:0] exc, input logic [31:0] epc);
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_if  = rif;
        stallreq_id  = rid;
        stallreq_ex  = rex;
        stallreq_mem = rmem;
        excepttype   = exc;
        cp0_epc      = epc;
        #2;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic [31:0] e_pc);
        chk({tag, "_stall"}, {26'h0, stall}, {26'h0, e_stall});
        chk({tag, "_flush"}, {31'h0, flush}, {31'h0, e_flush});
        chk({tag, "_newpc"}, new_pc, e_pc);
    endtask

    initial begin
        rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excepttype = 0; cp0_epc = 0;

        // Reset masks outputs even with active requests and an exception.
        drive(1, 1, 1, 1, 1, 32'h8, 32'h1234);
        chk_out("rst_hold", 6'b000000, 0, 32'h0);
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("idle", 6'b000000, 0, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        chk("rst_flush_cnt", flush_cnt, 32'h0);

        // Stall priority
        drive(0, 0, 1, 1, 0, 32'h0, 32'h0);
        chk_out("ex_id", 6'b001111, 0, 32'h0);
        drive(0, 1, 1, 1, 1, 32'h0, 32'h0);
        chk_out("mem_all", 6'b011111, 0, 32'h0);
        drive(0, 0, 1, 0, 0, 32'h0, 32'h0);
        chk_out("id_only", 6'b000111, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk_out("if_only", 6'b000111, 0, 32'h0);

        // Immediate exception with concurrent ex/id stall requests: flush wins.
        drive(0, 0, 1, 1, 0, 32'h8, 32'h12345678);
        chk_out("exc_imm", 6'b000000, 1, 32'hBFC00380);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("exc_imm_after", 6'b000000, 0, 32'h0);

        // Immediate eret redirects to live EPC
        drive(0, 0, 0, 0, 0, 32'he, 32'h80001234);
        chk_out("eret_imm", 6'b000000, 1, 32'h80001234);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);

        // eret behind a 3-cycle mem transaction; live inputs change during drain.
        drive(0, 0, 0, 0, 1, 32'he, 32'hBFC00100);
        chk_out("drain_c1", 6'b111111, 0, 32'h0);
        drive(0, 0, 1, 1, 1, 32'h8, 32'h0000AAAA);
        chk_out("drain_c2", 6'b111111, 0, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
        chk_out("drain_c3", 6'b111111, 0, 32'h0);
        drive(0, 0, 1, 0, 0, 32'h0, 32'h0);
        chk_out("drain_flush", 6'b000000, 1, 32'hBFC00100);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("drain_after", 6'b000000, 0, 32'h0);

        // Reset in the 2nd drain cycle discards the pending exception.
        drive(0, 1, 0, 0, 0, 32'h8, 32'h0);
        chk_out("rstd_c0", 6'b111111, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk_out("rstd_c1", 6'b111111, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        chk_out("rstd_c2", 6'b000000, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("rstd_after", 6'b000000, 0, 32'h0);
        drive(0, 0, 0, 1, 0, 32'h0, 32'h0);
        chk_out("rstd_run", 6'b001111, 0, 32'h0);

        // Counter scenario: fresh reset, 5 stalled cycles, 2 flushes.
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h8, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'he, 32'h4);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cnt", stall_cnt, 32'd5);
        chk("perf_flush_cnt", flush_cnt, 32'd2);
`else
        chk("perf_stall_cnt", stall_cnt, 32'd0);
        chk("perf_flush_cnt", flush_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
